debug_ctrl: RTL and testbench
=============================

# debug_ctrl

Board-level debug controller between the CPU and the 32-bit LED bank. It debounces the four view-select buttons and a step button, holds the selected debug view (ALU result, RAM data, ZF/OF flags, PC), optionally auto-rotates through the views, and sequences CPU execution (single-step or free-run) through a clock-enable. The LED word is registered and snapshotted after each step, so the display is stable.

## Interface
- DEB_CYCLES, default 20, consecutive stable cycles required to accept a button level change (≥2).
- AUTO_PERIOD, default 50000000, cycles per view in auto-scan mode (≥2).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_sel  in  4  raw select buttons; bit0=ALU_F, bit1=RAM_DATA, bit2=ZF_OF, bit3=PC.
- btn_step  in  1  raw single-step button.
- run_sw  in  1  level switch: 1 = free-run, 0 = step mode.
- auto_sw  in  1  level switch: 1 = auto-scan views.
- alu_f, ram_data, zf_of, pc  in  32 each  CPU debug words.
- cpu_ce  out  1  CPU clock-enable.
- sel  out  3  current view: 0 blank, 1 ALU_F, 2 RAM_DATA, 3 ZF_OF, 4 PC.
- led  out  32  registered LED word.

## Operation
- Debounce (5 identical channels): 2-flop synchronizer; counter counts consecutive cycles where the synchronized value differs from the debounced level; counter clears whenever they match; when the count reaches DEB_CYCLES the debounced level takes the new value and the counter clears. Press pulse = registered rising edge of the debounced level, high exactly one cycle.
- View select: press on bit k sets sel = k+1; press on the channel equal to current sel clears sel to 0 (toggle). Simultaneous presses: lowest bit wins, others ignored.
- Auto-scan (auto_sw=1): period timer counts 0..AUTO_PERIOD-1; at wrap sel advances 1→2→3→4→1; sel=0 advances to 1. A select press in auto mode applies as above and clears the timer. auto_sw=0 clears the timer and freezes sel.
- Step FSM, states IDLE, STEP, RUN:
  - IDLE: cpu_ce=0. run_sw=1 → RUN. Else step press → STEP.
  - STEP: cpu_ce=1 for exactly this one cycle; → IDLE unconditionally.
  - RUN: cpu_ce=1 every cycle; run_sw=0 → IDLE (cpu_ce=0 from the next cycle).
  - Step presses in RUN or STEP are dropped; no queuing.
- LED register: led <= mux(sel) of debug inputs (sel=0 → 0).
  - RUN: updated every cycle.
  - IDLE: updated the cycle after STEP exits, after any sel change, and on reset; otherwise held.
- Reset: led=0, sel=0, cpu_ce=0, FSM=IDLE, all synchronizers, debounced levels, counters and timer = 0. Reset mid-debounce or mid-step discards pending state; no pulse or ce survives reset.

## Timing
- Raw button changes before edge 0 and holds: debounced level updates at edge DEB_CYCLES+2; press pulse high in the cycle after edge DEB_CYCLES+3.
- Glitch shorter than DEB_CYCLES cycles: no level change, no pulse.
- Press pulse → sel updated next edge; led reflects new sel one edge later (2 cycles).
- Step press pulse → cpu_ce high the next cycle for one cycle → led snapshot updated the edge after cpu_ce falls.
- run_sw change seen by FSM directly (switch is quasi-static; passed through a 2-flop synchronizer only, no debounce).
- Auto-scan: sel changes every AUTO_PERIOD cycles exactly.

## Test plan
- Reset: assert rst 3 cycles with all buttons pressed → led=0, sel=0, cpu_ce=0; after release, with buttons still held, exactly one press pulse per channel after DEB_CYCLES+3 cycles (lowest-bit select wins: sel=1).
- Debounce (DEB_CYCLES=4): btn_sel[1] bounces 1-0-1-0 at 1-cycle spacing then holds 1 → single sel=2, led=ram_data; a 3-cycle pulse → no change.
- Toggle/priority: press bit2 → sel=3; press bit2 again → sel=0, led=0; press bits 3 and 0 together → sel=1.
- Single-step: run_sw=0, pc=0x00000010, press step → exactly one cpu_ce cycle; bench changes pc to 0x00000014 on that ce → led=0x00000014 and holds; hold step 100 cycles → still one ce.
- Free-run: run_sw=1 → cpu_ce continuous, led follows alu_f each cycle; drop run_sw → cpu_ce=0 within 3 cycles, led frozen.
- Auto-scan (AUTO_PERIOD=8): auto_sw=1 from sel=0 → sel 1,2,3,4,1 at 8-cycle intervals; select press mid-period restarts timer.

Source files
------------

// File: rtl/debug_ctrl_if.sv
// Board-side bundle of the debug controller: raw buttons, mode switches, CPU debug words,
// and the clock-enable / view / LED outputs.
interface debug_ctrl_if;
  logic [3:0]  btn_sel;
  logic        btn_step;
  logic        run_sw;
  logic        auto_sw;
  logic [31:0] alu_f;
  logic [31:0] ram_data;
  logic [31:0] zf_of;
  logic [31:0] pc;
  logic        cpu_ce;
  logic [2:0]  sel;
  logic [31:0] led;

  // Board / CPU side: drives buttons, switches and debug words; observes the controller.
  modport master (
    output btn_sel, btn_step, run_sw, auto_sw, alu_f, ram_data, zf_of, pc,
    input  cpu_ce, sel, led
  );

  // Controller side.
  modport slave (
    input  btn_sel, btn_step, run_sw, auto_sw, alu_f, ram_data, zf_of, pc,
    output cpu_ce, sel, led
  );
endinterface

// File: rtl/debug_ctrl.sv
// Debug controller: debounces view/step buttons, holds or auto-rotates the LED view,
// and sequences CPU execution (single-step / free-run) through a registered clock-enable.
module debug_ctrl #(
  parameter int unsigned DEB_CYCLES  = 20,
  parameter int unsigned AUTO_PERIOD = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  debug_ctrl_if.slave bus
);

  localparam int NCH = 5;                          // btn_sel[3:0] + btn_step
  localparam int DW  = $clog2(DEB_CYCLES + 1);
  localparam int TW  = $clog2(AUTO_PERIOD);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES);
  localparam logic [TW-1:0] AUTO_LAST = TW'(AUTO_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_RUN
  } state_e;

  // ---------------------------------------------------------------------------
  // Button debounce, one identical channel per button
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] btn_raw;
  logic [NCH-1:0] btn_sync1_q, btn_sync2_q;
  logic [NCH-1:0] level_q, level_dly_q, press_q;
  logic [DW-1:0]  deb_cnt_q [NCH];

  assign btn_raw = {bus.btn_step, bus.btn_sel};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values,
  // which is what makes the synchronizer chain and edge detector behave as registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      // NOTE: this counter array is a handful of flops, not a RAM, so resetting it in a
      // loop costs nothing and guarantees no half-finished debounce survives reset.
      for (int i = 0; i < NCH; i++) deb_cnt_q[i] <= '0;
    end else begin
      btn_sync1_q <= btn_raw;
      btn_sync2_q <= btn_sync1_q;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      for (int i = 0; i < NCH; i++) begin
        if (btn_sync2_q[i] == level_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          level_q[i]   <= btn_sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Mode switches are quasi-static: synchronize only, no debounce.
  logic [1:0] sw_sync1_q, sw_sync2_q;
  logic       run_s, auto_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= {bus.auto_sw, bus.run_sw};
      sw_sync2_q <= sw_sync1_q;
    end
  end

  assign run_s  = sw_sync2_q[0];
  assign auto_s = sw_sync2_q[1];

  // ---------------------------------------------------------------------------
  // View select and auto-scan
  // ---------------------------------------------------------------------------
  logic [2:0]    sel_q, sel_d, pick;
  logic [TW-1:0] timer_q, timer_d;
  logic          sel_chg_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sel_d   = sel_q;
    timer_d = timer_q;
    pick    = 3'd0;

    // Simultaneous presses: lowest bit wins.
    if      (press_q[0]) pick = 3'd1;
    else if (press_q[1]) pick = 3'd2;
    else if (press_q[2]) pick = 3'd3;
    else if (press_q[3]) pick = 3'd4;

    if (!auto_s)                timer_d = '0;
    else if (timer_q == AUTO_LAST) timer_d = '0;
    else                        timer_d = timer_q + 1'b1;

    if (pick != 3'd0) begin
      sel_d   = (sel_q == pick) ? 3'd0 : pick;
      timer_d = '0;
    end else if (auto_s && (timer_q == AUTO_LAST)) begin
      sel_d = (sel_q == 3'd4) ? 3'd1 : sel_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= 3'd0;
      timer_q   <= '0;
      sel_chg_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      sel_chg_q <= (sel_d != sel_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Step / run sequencer with registered clock-enable
  // ---------------------------------------------------------------------------
  state_e state_q;
  logic   cpu_ce_q;
  logic   snap_q;      // one-cycle strobe: refresh the LED word after a step retires

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cpu_ce_q <= 1'b0;
      snap_q   <= 1'b0;
    end else begin
      snap_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_s) begin
            state_q  <= S_RUN;
            cpu_ce_q <= 1'b1;
          end else if (press_q[4]) begin
            state_q  <= S_STEP;
            cpu_ce_q <= 1'b1;
          end else begin
            cpu_ce_q <= 1'b0;
          end
        end
        S_STEP: begin
          state_q  <= S_IDLE;
          cpu_ce_q <= 1'b0;
          snap_q   <= 1'b1;
        end
        S_RUN: begin
          if (!run_s) begin
            state_q  <= S_IDLE;
            cpu_ce_q <= 1'b0;
          end else begin
            cpu_ce_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cpu_ce_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // LED word: live in RUN, otherwise a snapshot refreshed only on step or view change
  // ---------------------------------------------------------------------------
  logic [31:0] led_mux, led_q;

  always_comb begin
    led_mux = '0;
    case (sel_q)
      3'd1:    led_mux = bus.alu_f;
      3'd2:    led_mux = bus.ram_data;
      3'd3:    led_mux = bus.zf_of;
      3'd4:    led_mux = bus.pc;
      default: led_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else if ((state_q == S_RUN) || snap_q || sel_chg_q) begin
      led_q <= led_mux;
    end
  end

  assign bus.cpu_ce = cpu_ce_q;
  assign bus.sel    = sel_q;
  assign bus.led    = led_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Self-checking bench for debug_ctrl: table-driven select vectors, hand-written timing
// sequences, and randomized press/glitch traffic checked against a press-level model.
module tb_debug_ctrl;

  localparam int DEB  = 4;
  localparam int AUTO = 8;
  localparam int SETTLE = DEB + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  debug_ctrl_if bus ();

  debug_ctrl #(.DEB_CYCLES(DEB), .AUTO_PERIOD(AUTO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] mask;
    logic [2:0] exp_sel;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // View-select rule: lowest pressed bit k selects k+1, or clears if already selected.
  function automatic logic [2:0] model_sel(input logic [2:0] cur, input logic [3:0] mask);
    int k;
    k = 0;
    while (k < 3 && !mask[k]) k++;
    return (int'(cur) == k + 1) ? 3'd0 : 3'(k + 1);
  endfunction

  function automatic logic [31:0] model_led(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] r, input logic [31:0] z,
                                            input logic [31:0] p);
    case (s)
      3'd1:    return a;
      3'd2:    return r;
      3'd3:    return z;
      3'd4:    return p;
      default: return 32'd0;
    endcase
  endfunction

  task automatic press(input logic [3:0] mask);
    bus.btn_sel = mask;
    repeat (SETTLE) @(negedge clk);
    bus.btn_sel = 4'd0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic wait_sel_change(input int budget, output logic [2:0] val, output int at);
    logic [2:0] prev;
    logic       seen;
    prev = bus.sel;
    seen = 1'b0;
    val  = prev;
    at   = cyc;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.sel !== prev) begin
        seen = 1'b1;
        val  = bus.sel;
        at   = cyc;
      end
    end
    check("sel_change_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    vec_t        vecs [8];
    logic [2:0]  m_sel, v;
    logic [31:0] last_alu, val;
    int          t_prev, t_now, ce_cnt;
    logic        seen;
    logic [3:0]  gmask;
    int          glen;

    vecs[0] = '{4'b0100, 3'd3};
    vecs[1] = '{4'b0100, 3'd0};
    vecs[2] = '{4'b1001, 3'd1};
    vecs[3] = '{4'b0001, 3'd0};
    vecs[4] = '{4'b0010, 3'd2};
    vecs[5] = '{4'b1110, 3'd0};
    vecs[6] = '{4'b1000, 3'd4};
    vecs[7] = '{4'b1100, 3'd3};

    bus.btn_sel  = 4'hF;
    bus.btn_step = 1'b1;
    bus.run_sw   = 1'b0;
    bus.auto_sw  = 1'b0;
    bus.alu_f    = 32'hA1A1_0001;
    bus.ram_data = 32'hB2B2_0002;
    bus.zf_of    = 32'h0000_0003;
    bus.pc       = 32'hC4C4_0004;

    // Reset with every button held, then exact debounce/press latency after release.
    repeat (3) @(negedge clk);
    check("rst_led", bus.led, 32'd0);
    check("rst_sel", {29'd0, bus.sel}, 32'd0);
    check("rst_ce", {31'd0, bus.cpu_ce}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("rel_sel", {29'd0, bus.sel}, (k >= DEB + 4) ? 32'd1 : 32'd0);
      check("rel_ce", {31'd0, bus.cpu_ce}, (k == DEB + 4) ? 32'd1 : 32'd0);
    end
    check("rel_led", bus.led, 32'hA1A1_0001);
    bus.btn_sel  = 4'd0;
    bus.btn_step = 1'b0;
    repeat (SETTLE) @(negedge clk);
    check("release_sel", {29'd0, bus.sel}, 32'd1);

    // Bouncy press on bit1, then a too-short pulse on bit0.
    for (int i = 0; i < 4; i++) begin
      bus.btn_sel = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    bus.btn_sel = 4'b0010;
    repeat (SETTLE) @(negedge clk);
    check("bounce_sel", {29'd0, bus.sel}, 32'd2);
    check("bounce_led", bus.led, 32'hB2B2_0002);
    bus.btn_sel = 4'd0;
    repeat (SETTLE) @(negedge clk);
    bus.btn_sel = 4'b0001;
    repeat (DEB - 1) @(negedge clk);
    bus.btn_sel = 4'd0;
    repeat (SETTLE) @(negedge clk);
    check("glitch_sel", {29'd0, bus.sel}, 32'd2);

    // Toggle / priority table.
    for (int i = 0; i < 8; i++) begin
      press(vecs[i].mask);
      check($sformatf("vec%0d_sel", i), {29'd0, bus.sel}, {29'd0, vecs[i].exp_sel});
      check($sformatf("vec%0d_led", i), bus.led,
            model_led(vecs[i].exp_sel, 32'hA1A1_0001, 32'hB2B2_0002, 32'h0000_0003, 32'hC4C4_0004));
    end

    // Single-step with step held for 100 cycles.
    bus.pc = 32'h0000_0010;
    press(4'b1000);
    check("step_view_sel", {29'd0, bus.sel}, 32'd4);
    check("step_pre_led", bus.led, 32'h0000_0010);
    ce_cnt = 0;
    bus.btn_step = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cpu_ce) begin
        ce_cnt++;
        bus.pc = 32'h0000_0014;
      end
    end
    check("step_ce_count", ce_cnt, 32'd1);
    check("step_led", bus.led, 32'h0000_0014);
    bus.btn_step = 1'b0;
    repeat (SETTLE) @(negedge clk);
    bus.pc = 32'h0000_0018;
    repeat (10) @(negedge clk);
    check("step_led_hold", bus.led, 32'h0000_0014);

    // Free-run: LED follows alu_f every cycle, then freezes when run drops.
    press(4'b0001);
    check("run_view_sel", {29'd0, bus.sel}, 32'd1);
    bus.run_sw = 1'b1;
    repeat (4) @(negedge clk);
    last_alu = 32'd0;
    for (int i = 0; i < 10; i++) begin
      last_alu = $urandom;
      bus.alu_f = last_alu;
      @(negedge clk);
      check("run_ce", {31'd0, bus.cpu_ce}, 32'd1);
      check("run_led", bus.led, last_alu);
    end
    bus.run_sw = 1'b0;
    repeat (3) @(negedge clk);
    check("run_stop_ce", {31'd0, bus.cpu_ce}, 32'd0);
    bus.alu_f = ~last_alu;
    repeat (5) @(negedge clk);
    check("run_frozen_led", bus.led, last_alu);
    check("run_stop_ce2", {31'd0, bus.cpu_ce}, 32'd0);

    // Auto-scan from sel=0, then a select press mid-period restarts the timer.
    press(4'b0001);
    check("auto_start_sel", {29'd0, bus.sel}, 32'd0);
    bus.auto_sw = 1'b1;
    wait_sel_change(40, v, t_prev);
    check("auto_first", {29'd0, v}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_sel_change(20, v, t_now);
      check("auto_seq", {29'd0, v}, (i == 3) ? 32'd1 : 32'(i + 2));
      check("auto_interval", t_now - t_prev, AUTO);
      t_prev = t_now;
    end
    repeat (3) @(negedge clk);
    bus.btn_sel = 4'b0100;
    wait_sel_change(20, v, t_now);
    check("auto_pre_press", {29'd0, v}, 32'd2);
    check("auto_pre_interval", t_now - t_prev, AUTO);
    t_prev = t_now;
    wait_sel_change(20, v, t_now);
    check("auto_press", {29'd0, v}, 32'd3);
    check("auto_press_interval", t_now - t_prev, 4);
    t_prev = t_now;
    wait_sel_change(20, v, t_now);
    check("auto_restart", {29'd0, v}, 32'd4);
    check("auto_restart_interval", t_now - t_prev, AUTO);
    bus.btn_sel = 4'd0;
    bus.auto_sw = 1'b0;
    repeat (30) @(negedge clk);
    check("auto_freeze", {29'd0, bus.sel}, 32'd4);

    // Randomized presses and sub-threshold glitches against the press-level model.
    m_sel = 3'd4;
    for (int it = 0; it < 12; it++) begin
      bus.alu_f    = $urandom;
      bus.ram_data = $urandom;
      bus.zf_of    = $urandom;
      bus.pc       = $urandom;
      gmask = 4'($urandom_range(1, 15));
      press(gmask);
      m_sel = model_sel(m_sel, gmask);
      check("rnd_sel", {29'd0, bus.sel}, {29'd0, m_sel});
      check("rnd_led", bus.led, model_led(m_sel, bus.alu_f, bus.ram_data, bus.zf_of, bus.pc));
      gmask = 4'($urandom_range(1, 15));
      glen  = $urandom_range(1, DEB - 1);
      bus.btn_sel = gmask;
      repeat (glen) @(negedge clk);
      bus.btn_sel = 4'd0;
      repeat (SETTLE) @(negedge clk);
      check("rnd_glitch_sel", {29'd0, bus.sel}, {29'd0, m_sel});
    end

    // Reset in the middle of a debounce: pending presses are discarded.
    bus.btn_sel  = 4'b1000;
    bus.btn_step = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.btn_sel  = 4'd0;
    bus.btn_step = 1'b0;
    rst = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cpu_ce) ce_cnt++;
    end
    check("middeb_sel", {29'd0, bus.sel}, 32'd0);
    check("middeb_led", bus.led, 32'd0);
    check("middeb_ce", ce_cnt, 32'd0);

    // Reset while cpu_ce is high: no ce or snapshot survives.
    bus.btn_step = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.cpu_ce) seen = 1'b1;
    end
    check("midstep_ce_seen", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    bus.btn_step = 1'b0;
    @(negedge clk);
    check("midstep_ce", {31'd0, bus.cpu_ce}, 32'd0);
    rst = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cpu_ce) ce_cnt++;
    end
    check("midstep_ce_after", ce_cnt, 32'd0);
    val = bus.led;
    check("midstep_led", val, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
